// File: rtl/priority_irq_ctrl.sv
// Priority interrupt controller: latches rising request edges per channel,
// presents the highest unmasked pending channel as {valid, index} and holds
// it until ack, enable drop, or (when PREEMPT=1) a higher-priority arrival.

// Per-channel edge detector and pending latch.
module irq_chan (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic clr,
  output logic pend
);
  logic req_d;

  // Set on a rising req edge; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_d <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_d <= req;
      pend  <= (pend & ~clr) | (req & ~req_d);
    end
  end
endmodule

module priority_irq_ctrl #(
  parameter int N       = 8,
  parameter int PREEMPT = 0,
  localparam int W      = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic [W:0]   out,
  output logic [N-1:0] pending,
  output logic         busy
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] cur_id;
  logic [N-1:0] elig;
  logic [N-1:0] clr;
  logic [W-1:0] top_id;
  logic         elig_any;
  logic         preempt_hit;

  // Highest set bit index; bit N-1 has top priority.
  function automatic logic [W-1:0] hi_idx(input logic [N-1:0] v);
    logic [W-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) f = W'(i);
    return f;
  endfunction

  assign elig     = pending & ~mask;
  assign elig_any = |elig;
  assign top_id   = hi_idx(elig);
  // Preemption only looks upward from the presented channel.
  assign preempt_hit = (PREEMPT != 0) && elig_any && (top_id > cur_id);

  // Ack clears the presented channel only while presenting with enable high.
  always_comb begin
    clr = '0;
    if (state == PRESENT && enable && ack) clr[cur_id] = 1'b1;
  end

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_chan
      irq_chan u_chan (
        .clk   (clk),
        .reset (reset),
        .req   (req[k]),
        .clr   (clr[k]),
        .pend  (pending[k])
      );
    end
  endgenerate

  // IDLE/PRESENT control with registered out, busy and cur_id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cur_id <= '0;
      out    <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && elig_any) begin
            state  <= PRESENT;
            cur_id <= top_id;
            out    <= {1'b1, top_id};
            busy   <= 1'b1;
          end else begin
            out  <= '0;
            busy <= 1'b0;
          end
        end
        PRESENT: begin
          if (!enable || ack) begin
            // Enable drop abandons the grant without clearing pending.
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
          end else if (preempt_hit) begin
            cur_id <= top_id;
            out    <= {1'b1, top_id};
          end
        end
        default: begin
          state <= IDLE;
          out   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/priority_irq_ctrl.md
PRIORITY_IRQ_CTRL -- requirements
Module: priority_irq_ctrl

Interface
REQ-001 Parameter N, default 8, SHALL be the number of request channels (legal range 2..32).
REQ-002 Parameter PREEMPT, default 0, SHALL select preemption mode (0 = hold presented channel until ack, 1 = higher-priority pending channel replaces it).
REQ-003 Localparam W SHALL equal $clog2(N), the channel index width.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-006 enable  input  1  SHALL gate selection; low forces out to 0.
REQ-007 req  input  N  SHALL carry request lines; bit N-1 is highest priority.
REQ-008 mask  input  N  SHALL block selection of a channel when its bit is 1 (pending still latched).
REQ-009 ack  input  1  SHALL acknowledge the currently presented channel.
REQ-010 out  output  W+1  SHALL present {valid, index}: MSB 1 with channel index, or all-zero when nothing is presented.
REQ-011 pending  output  N  SHALL expose the latched pending register.
REQ-012 busy  output  1  SHALL be 1 exactly when the FSM is in PRESENT.

Function
REQ-013 A registered copy req_d SHALL detect rising edges; at a clock edge where req[k]=1 and req_d[k]=0, pending[k] SHALL be set.
REQ-014 The FSM SHALL have two states, IDLE and PRESENT; out, busy and the held index cur_id SHALL be registered.
REQ-015 IDLE: if enable=1 and (pending & ~mask) is nonzero, the next edge SHALL load cur_id with the highest set index, enter PRESENT, drive out={1,cur_id}; otherwise remain IDLE with out=0.
REQ-016 Latency: req rising before edge E0 sets pending at E0; with FSM idle and enable=1, out SHALL become valid at E1.
REQ-017 PRESENT: out SHALL hold stable until ack, enable drop, or preemption.
REQ-018 PRESENT with ack=1 at an edge: pending[cur_id] SHALL clear, FSM SHALL enter IDLE, out SHALL become 0; the next grant is at least one cycle later.
REQ-019 PRESENT with enable=0 at an edge: FSM SHALL enter IDLE, out=0, pending unchanged (ack ignored).
REQ-020 PRESENT, PREEMPT=1, no ack, and an unmasked pending index above cur_id: cur_id SHALL switch to the highest such index next edge, staying in PRESENT.
REQ-021 PREEMPT=0: masking or higher-priority arrival SHALL NOT change the presented channel.
REQ-022 ack and preemption condition at the same edge: ack SHALL win (old cur_id cleared, enter IDLE).
REQ-023 Same-bit set edge and ack clear at the same edge: set SHALL win, pending[k] stays 1.
REQ-024 ack while IDLE SHALL be ignored.
REQ-025 A level-high req SHALL set pending only once; re-trigger requires a low cycle.

Reset
REQ-026 reset=1 SHALL immediately, without a clock, force state IDLE, out=0, busy=0, pending=0, req_d=0, cur_id=0.
REQ-027 A req bit already high at reset release SHALL count as a rising edge on the first clock edge.
REQ-028 Reset asserted mid-PRESENT SHALL discard all pending requests and the presented channel.

Verification (N=8)
REQ-029 req=8'h05 pulse one cycle, enable=1 -> pending=8'h05, out=4'b1010 one edge later; ack -> out=0, pending=8'h01; next grant out=4'b1000.
REQ-030 mask=8'h80, req[7] and req[3] rise together -> out=4'b1011, pending=8'h88; clearing mask while presenting (PREEMPT=0) -> out unchanged until ack.
REQ-031 PREEMPT=1, presenting index 2, req[6] rises -> out=4'b1110 two edges later, busy stays 1; ack -> pending[6] cleared, pending[2] still 1.
REQ-032 Presenting index 4, enable dropped one cycle -> out=0, busy=0, pending[4]=1; enable restored -> out=4'b1100 again.
REQ-033 Presenting index 1, req[1] re-rises at the ack edge -> FSM IDLE, pending[1]=1, out=4'b1001 on re-grant.
REQ-034 reset pulsed mid-PRESENT with req=8'hFF held -> out=0 asynchronously; after release pending=8'hFF, then out=4'b1111.
